// File: rtl/shifter_ctrl_pkg.sv
// Shared types and constants for the shifter_ctrl command sequencer.
// Optional round-robin arbitration is enabled with SHIFTER_CTRL_RR_EN.
package shifter_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_SHR  = 2'b01,
        OP_SHL  = 2'b10,
        OP_READ = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } state_e;

    localparam logic [2:0] PC_LOAD = 3'b000;
    localparam logic [2:0] PC_SR   = 3'b010;
    localparam logic [2:0] PC_SL   = 3'b100;

    function automatic logic op_shifts(input op_e op);
        return (op == OP_SHR) || (op == OP_SHL);
    endfunction

endpackage

// File: rtl/shifter_ctrl_arb.sv
// Two-way request arbiter: fixed req0 priority, or round-robin when
// SHIFTER_CTRL_RR_EN is defined.
module shifter_ctrl_arb
    import shifter_ctrl_pkg::*;
(
`ifdef SHIFTER_CTRL_RR_EN
    input  logic clk,
    input  logic clr,
`endif
    input  logic enable,
    input  logic valid0,
    input  logic valid1,
    output logic ready0,
    output logic ready1,
    output logic grant_id
);

`ifdef SHIFTER_CTRL_RR_EN
    logic last_grant;

    // On contention, favour whichever requester was not served last.
    always_comb begin
        if (valid0 && valid1) begin
            grant_id = ~last_grant;
        end else begin
            grant_id = valid1 && !valid0;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            last_grant <= 1'b1;
        end else if (ready0 || ready1) begin
            last_grant <= grant_id;
        end
    end
`else
    always_comb begin
        grant_id = valid1 && !valid0;
    end
`endif

    always_comb begin
        ready0 = enable && valid0 && !grant_id;
        ready1 = enable && valid1 && grant_id;
    end

endmodule

// File: rtl/shifter_ctrl.sv
// Two-requester command sequencer driving a shifter's load/shift controls.
// Define SHIFTER_CTRL_RR_EN for round-robin arbitration between requesters.
module shifter_ctrl
    import shifter_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_data,
    input  logic [CNT_W-1:0] req0_cnt,
    input  logic             req0_fill,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_data,
    input  logic [CNT_W-1:0] req1_cnt,
    input  logic             req1_fill,
    output logic             done,
    output logic             done_id,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic [WIDTH-1:0] sh_D,
    output logic             sh_D_sr,
    output logic             sh_D_sl,
    output logic             sh_ld,
    output logic             sh_sr,
    output logic             sh_sl,
    output logic [2:0]       sh_prior_con,
    input  logic [WIDTH-1:0] sh_Q
);

    state_e           state;
    state_e           state_nxt;
    op_e              op_q;
    logic [WIDTH-1:0] data_q;
    logic [CNT_W-1:0] cnt_q;
    logic             fill_q;
    logic             id_q;
    logic             arb_enable;
    logic             grant_id;
    logic             accept;
    op_e              sel_op;

    // Gating with clr keeps both readys low while reset is asserted.
    assign arb_enable = (state == ST_IDLE) && clr;

    shifter_ctrl_arb u_arb (
`ifdef SHIFTER_CTRL_RR_EN
        .clk      (clk),
        .clr      (clr),
`endif
        .enable   (arb_enable),
        .valid0   (req0_valid),
        .valid1   (req1_valid),
        .ready0   (req0_ready),
        .ready1   (req1_ready),
        .grant_id (grant_id)
    );

    assign accept = req0_ready || req1_ready;
    assign sel_op = grant_id ? op_e'(req1_op) : op_e'(req0_op);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            op_q   <= OP_LOAD;
            data_q <= '0;
            cnt_q  <= '0;
            fill_q <= 1'b0;
            id_q   <= 1'b0;
        end else if (accept) begin
            op_q   <= sel_op;
            data_q <= grant_id ? req1_data : req0_data;
            cnt_q  <= grant_id ? req1_cnt  : req0_cnt;
            fill_q <= grant_id ? req1_fill : req0_fill;
            id_q   <= grant_id;
        end else if (state == ST_SHIFT) begin
            cnt_q  <= cnt_q - CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = (sel_op == OP_READ) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_nxt = (op_shifts(op_q) && (cnt_q != '0)) ? ST_SHIFT : ST_DONE;
            end
            ST_SHIFT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        sh_D         = '0;
        sh_D_sr      = 1'b0;
        sh_D_sl      = 1'b0;
        sh_ld        = 1'b0;
        sh_sr        = 1'b0;
        sh_sl        = 1'b0;
        sh_prior_con = PC_LOAD;
        done         = 1'b0;
        done_id      = 1'b0;
        result       = '0;
        busy         = (state != ST_IDLE);
        case (state)
            ST_LOAD: begin
                sh_ld        = 1'b1;
                sh_D         = data_q;
                sh_prior_con = PC_LOAD;
            end
            ST_SHIFT: begin
                sh_D_sr = fill_q;
                sh_D_sl = fill_q;
                if (op_q == OP_SHL) begin
                    sh_sl        = 1'b1;
                    sh_prior_con = PC_SL;
                end else begin
                    sh_sr        = 1'b1;
                    sh_prior_con = PC_SR;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                done_id = id_q;
                result  = sh_Q;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_shifter_ctrl.sv
// Directed self-checking bench for shifter_ctrl with a behavioural shifter.
// Honours SHIFTER_CTRL_RR_EN for the repeated-contention expectations.
module tb_shifter_ctrl;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             clr = 1'b0;
    logic             req0_valid = 1'b0;
    logic             req0_ready;
    logic [1:0]       req0_op = 2'b00;
    logic [WIDTH-1:0] req0_data = '0;
    logic [CNT_W-1:0] req0_cnt = '0;
    logic             req0_fill = 1'b0;
    logic             req1_valid = 1'b0;
    logic             req1_ready;
    logic [1:0]       req1_op = 2'b00;
    logic [WIDTH-1:0] req1_data = '0;
    logic [CNT_W-1:0] req1_cnt = '0;
    logic             req1_fill = 1'b0;
    logic             done;
    logic             done_id;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic [WIDTH-1:0] sh_D;
    logic             sh_D_sr;
    logic             sh_D_sl;
    logic             sh_ld;
    logic             sh_sr;
    logic             sh_sl;
    logic [2:0]       sh_prior_con;
    logic [WIDTH-1:0] sh_q = 4'b1001;

    int tests_run  = 0;
    int fail_count = 0;
    int ld_n = 0, sr_n = 0, sl_n = 0, busy_n = 0, done_n = 0;

    always #5 clk = ~clk;

    shifter_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .clr          (clr),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_op      (req0_op),
        .req0_data    (req0_data),
        .req0_cnt     (req0_cnt),
        .req0_fill    (req0_fill),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_op      (req1_op),
        .req1_data    (req1_data),
        .req1_cnt     (req1_cnt),
        .req1_fill    (req1_fill),
        .done         (done),
        .done_id      (done_id),
        .result       (result),
        .busy         (busy),
        .sh_D         (sh_D),
        .sh_D_sr      (sh_D_sr),
        .sh_D_sl      (sh_D_sl),
        .sh_ld        (sh_ld),
        .sh_sr        (sh_sr),
        .sh_sl        (sh_sl),
        .sh_prior_con (sh_prior_con),
        .sh_Q         (sh_q)
    );

    // Behavioural shifter; it has no reset so its contents survive clr.
    always @(posedge clk) begin
        if (sh_ld && sh_prior_con == 3'b000) begin
            sh_q <= sh_D;
        end else if (sh_sr && sh_prior_con == 3'b010) begin
            sh_q <= {sh_D_sr, sh_q[WIDTH-1:1]};
        end else if (sh_sl && sh_prior_con == 3'b100) begin
            sh_q <= {sh_q[WIDTH-2:0], sh_D_sl};
        end
    end

    always @(negedge clk) begin
        if (sh_ld) ld_n++;
        if (sh_sr) sr_n++;
        if (sh_sl) sl_n++;
        if (busy) busy_n++;
        if (done) done_n++;
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issues one command from a single requester and checks its completion.
    task automatic apply_stimulus(input string tag, input bit who, input logic [1:0] op,
                                  input logic [3:0] data, input logic [2:0] cnt, input logic fill,
                                  input logic [3:0] exp_res, input int exp_lat,
                                  input int exp_ld, input int exp_sr, input int exp_sl);
        int n;
        int k;
        int ld0, sr0, sl0, busy0;
        logic rdy;
        if (who) begin
            req1_op = op; req1_data = data; req1_cnt = cnt; req1_fill = fill; req1_valid = 1'b1;
        end else begin
            req0_op = op; req0_data = data; req0_cnt = cnt; req0_fill = fill; req0_valid = 1'b1;
        end
        #1;
        n = 0;
        rdy = who ? req1_ready : req0_ready;
        while (!rdy && n < 20) begin
            @(negedge clk); #1;
            n++;
            rdy = who ? req1_ready : req0_ready;
        end
        check_output({tag, " ready"}, {31'd0, rdy}, 32'd1);
        if (!rdy) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        ld0 = ld_n; sr0 = sr_n; sl0 = sl_n; busy0 = busy_n;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done && k < 20);
        #1;
        check_output({tag, " latency"}, k, exp_lat);
        check_output({tag, " done_id"}, {31'd0, done_id}, {31'd0, who});
        check_output({tag, " result"}, {28'd0, result}, {28'd0, exp_res});
        check_output({tag, " ld cycles"}, ld_n - ld0, exp_ld);
        check_output({tag, " sr cycles"}, sr_n - sr0, exp_sr);
        check_output({tag, " sl cycles"}, sl_n - sl0, exp_sl);
        check_output({tag, " busy cycles"}, busy_n - busy0, exp_lat);
        @(negedge clk); #1;
        check_output({tag, " done pulse width"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int base_done;
        int exp_id;

        // Reset state, with a pending request that must not be readied.
        req0_valid = 1'b1;
        #2;
        check_output("rst ready0", {31'd0, req0_ready}, 32'd0);
        check_output("rst busy", {31'd0, busy}, 32'd0);
        check_output("rst done", {31'd0, done}, 32'd0);
        check_output("rst result", {28'd0, result}, 32'd0);
        check_output("rst sh_ctrl", {29'd0, sh_ld, sh_sr, sh_sl}, 32'd0);
        check_output("rst sh_D", {28'd0, sh_D}, 32'd0);
        check_output("rst prior_con", {29'd0, sh_prior_con}, 32'd0);
        req0_valid = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        #1;

        // READ with nothing loaded: shifter holds its power-up value 1001.
        apply_stimulus("read_noload", 1'b0, 2'b11, 4'b0000, 3'd0, 1'b0, 4'b1001, 1, 0, 0, 0);

        // req0 SHR 0110 cnt=2 fill=1, stepped cycle by cycle.
        req0_op = 2'b01; req0_data = 4'b0110; req0_cnt = 3'd2; req0_fill = 1'b1; req0_valid = 1'b1;
        #1;
        check_output("shr ready0", {31'd0, req0_ready}, 32'd1);
        check_output("shr ready1", {31'd0, req1_ready}, 32'd0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk); #1;
        check_output("shr load ld", {31'd0, sh_ld}, 32'd1);
        check_output("shr load D", {28'd0, sh_D}, 32'h6);
        check_output("shr load pc", {29'd0, sh_prior_con}, 32'd0);
        check_output("shr load ready0", {31'd0, req0_ready}, 32'd0);
        @(negedge clk); #1;
        check_output("shr q0", {28'd0, sh_q}, 32'h6);
        check_output("shr sr", {31'd0, sh_sr}, 32'd1);
        check_output("shr pc", {29'd0, sh_prior_con}, 32'd2);
        check_output("shr fill", {30'd0, sh_D_sr, sh_D_sl}, 32'd3);
        @(negedge clk); #1;
        check_output("shr q1", {28'd0, sh_q}, 32'hB);
        check_output("shr done early", {31'd0, done}, 32'd0);
        @(negedge clk); #1;
        check_output("shr done", {31'd0, done}, 32'd1);
        check_output("shr done_id", {31'd0, done_id}, 32'd0);
        check_output("shr result", {28'd0, result}, 32'hD);
        check_output("shr done sr", {31'd0, sh_sr}, 32'd0);
        @(negedge clk); #1;
        check_output("shr idle busy", {31'd0, busy}, 32'd0);
        check_output("shr idle result", {28'd0, result}, 32'd0);

        // req1 SHL 0110 cnt=1 fill=0 -> 1100 at latency 3.
        apply_stimulus("shl_req1", 1'b1, 2'b10, 4'b0110, 3'd1, 1'b0, 4'b1100, 3, 1, 0, 1);

        // SHR with cnt=0 never shifts.
        apply_stimulus("shr_cnt0", 1'b0, 2'b01, 4'b1010, 3'd0, 1'b1, 4'b1010, 2, 1, 0, 0);

        // LOAD ignores cnt.
        apply_stimulus("load_cnt7", 1'b1, 2'b00, 4'b0111, 3'd7, 1'b1, 4'b0111, 2, 1, 0, 0);

        // Reset mid-SHIFT: SHL 0110 fill=1 cnt=5, drop clr after two shifts.
        req0_op = 2'b10; req0_data = 4'b0110; req0_cnt = 3'd5; req0_fill = 1'b1; req0_valid = 1'b1;
        #1;
        check_output("abort ready0", {31'd0, req0_ready}, 32'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check_output("abort pre busy", {31'd0, busy}, 32'd1);
        check_output("abort pre sl", {31'd0, sh_sl}, 32'd1);
        base_done = done_n;
        clr = 1'b0;
        req0_valid = 1'b1;
        #1;
        check_output("abort busy", {31'd0, busy}, 32'd0);
        check_output("abort sh_ctrl", {29'd0, sh_ld, sh_sr, sh_sl}, 32'd0);
        check_output("abort serial", {30'd0, sh_D_sr, sh_D_sl}, 32'd0);
        check_output("abort prior_con", {29'd0, sh_prior_con}, 32'd0);
        check_output("abort done", {31'd0, done}, 32'd0);
        check_output("abort ready0", {31'd0, req0_ready}, 32'd0);
        check_output("abort q", {28'd0, sh_q}, 32'hB);
        repeat (2) @(negedge clk);
        req0_valid = 1'b0;
        clr = 1'b1;
        @(negedge clk); #1;
        check_output("abort no done", done_n - base_done, 32'd0);
        check_output("abort idle busy", {31'd0, busy}, 32'd0);
        apply_stimulus("abort read", 1'b1, 2'b11, 4'b0000, 3'd0, 1'b0, 4'b1011, 1, 0, 0, 0);

        // Contention: req0 LOAD 0011 and req1 LOAD 0101, req0 served first.
        req0_op = 2'b00; req0_data = 4'b0011; req0_cnt = 3'd0; req0_valid = 1'b1;
        req1_op = 2'b00; req1_data = 4'b0101; req1_cnt = 3'd0; req1_valid = 1'b1;
        #1;
        check_output("cont ready0", {31'd0, req0_ready}, 32'd1);
        check_output("cont ready1", {31'd0, req1_ready}, 32'd0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_output("cont done a", {31'd0, done}, 32'd1);
        check_output("cont id a", {31'd0, done_id}, 32'd0);
        check_output("cont result a", {28'd0, result}, 32'h3);
        @(negedge clk); #1;
        check_output("cont ready1 b", {31'd0, req1_ready}, 32'd1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_output("cont done b", {31'd0, done}, 32'd1);
        check_output("cont id b", {31'd0, done_id}, 32'd1);
        check_output("cont result b", {28'd0, result}, 32'h5);
        @(negedge clk); #1;

        // Both requesters held valid across two grants.
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
`ifdef SHIFTER_CTRL_RR_EN
            exp_id = i;
`else
            exp_id = 0;
`endif
            check_output("hold ready0", {31'd0, req0_ready}, (exp_id == 0) ? 32'd1 : 32'd0);
            check_output("hold ready1", {31'd0, req1_ready}, (exp_id == 1) ? 32'd1 : 32'd0);
            repeat (2) @(negedge clk);
            #1;
            check_output("hold done", {31'd0, done}, 32'd1);
            check_output("hold id", {31'd0, done_id}, exp_id);
            check_output("hold result", {28'd0, result}, (exp_id == 1) ? 32'h5 : 32'h3);
            @(negedge clk);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule

// File: doc/shifter_ctrl.md
Name: shifter_ctrl

Overview:
Two-requester command sequencer for the `shifter` datapath (parallel load, shift-right, shift-left, prior_con priority control).
- Arbitrates between two clients and latches the winning command.
- Drives the shifter's control pins through LOAD then N SHIFT cycles.
- Returns the final Q with a one-cycle done pulse tagged with the requester ID.
- Sits between the shifter instance and its users; it is the only block allowed to drive the shifter controls.

Parameters:
- WIDTH, 4, shifter data width; must match the shifter instance.
- CNT_W, 3, width of the shift-count field (max 2^CNT_W-1 shifts per command).

Ports:
- clk  in  1  single clock, rising edge.
- clr  in  1  asynchronous, active-low reset.
- req0_valid / req1_valid  in  1  command valid per requester.
- req0_ready / req1_ready  out  1  command accepted this cycle.
- req0_op / req1_op  in  2  00 LOAD, 01 LOAD+SHR, 10 LOAD+SHL, 11 READ.
- req0_data / req1_data  in  WIDTH  value to load.
- req0_cnt / req1_cnt  in  CNT_W  number of shift cycles.
- req0_fill / req1_fill  in  1  serial fill bit for the shifts.
- done  out  1  one-cycle completion pulse.
- done_id  out  1  requester that owns the completed command.
- result  out  WIDTH  shifter Q, valid while done=1.
- busy  out  1  high in any state other than IDLE.
- sh_D  out  WIDTH  to shifter D.
- sh_D_sr, sh_D_sl  out  1  to shifter serial inputs.
- sh_ld, sh_sr, sh_sl  out  1  to shifter controls.
- sh_prior_con  out  3  to shifter prior_con.
- sh_Q  in  WIDTH  from shifter Q.

Behaviour:
- Shifter contract (WIDTH=4 example):
  - ld with prior_con=000 gives Q<=D.
  - sr with prior_con=010 gives Q<={D_sr,Q[W-1:1]}.
  - sl with prior_con=100 gives Q<={Q[W-2:0],D_sl}.
- Reset (clr=0, asynchronous): state=IDLE; every output 0, including ready, done, busy and all sh_* signals. Any in-flight command is dropped with no done.
- FSM states: IDLE, LOAD, SHIFT, DONE. State, latched command and count are registers; sh_*, done and busy are decoded from registers only (Moore).
- IDLE:
  - Arbitration is combinational on the valids. Fixed priority: req0 beats req1.
  - The grant's ready=1 while its valid=1; the other ready=0. ready is never high outside IDLE.
  - valid&ready latches op, data, cnt, fill and id.
  - Next state: READ goes to DONE; every other op goes to LOAD.
  - A requester must hold valid and its fields stable until accepted.
- LOAD (1 cycle):
  - sh_ld=1, sh_D=latched data, sh_prior_con=000.
  - Next state: SHIFT if op is SHR/SHL and cnt!=0; otherwise DONE. op LOAD ignores cnt.
- SHIFT (exactly cnt cycles):
  - SHR: sh_sr=1, prior_con=010.
  - SHL: sh_sl=1, prior_con=100.
  - Both sh_D_sr and sh_D_sl = fill.
  - The down-counter decrements each cycle; leave to DONE when it hits 1.
- DONE (1 cycle): done=1, done_id=latched id, result=sh_Q. Then return to IDLE.
- A new command can be accepted in the cycle after DONE. There is no back-to-back overlap.
- Outside their active states: sh_ld/sr/sl=0, prior_con=000, sh_D=0, result=0.
- Latency, counted from the accept edge to the done cycle:
  - LOAD/SHR/SHL: cnt+2 cycles (cnt treated as 0 for LOAD).
  - READ: 1 cycle.
- If both valids are high in IDLE, only one is accepted; the loser keeps valid high and waits.

Optional Feature:
Macro SHIFTER_CTRL_RR_EN.
- Defined: round-robin arbitration. A 1-bit last-grant register (reset to 1, so req0 wins first) gives priority to the requester not served last. It updates only on accept.
- Undefined: fixed priority, req0 over req1; no extra register.

Decomposition:
- Package shifter_ctrl_pkg holds:
  - the op enum: OP_LOAD=2'b00, OP_SHR=2'b01, OP_SHL=2'b10, OP_READ=2'b11;
  - the state enum;
  - prior_con constants: PC_LOAD=3'b000, PC_SR=3'b010, PC_SL=3'b100.
- One natural sub-module: shifter_ctrl_arb, a 2-way arbiter with optional round-robin that produces the grant and the readys.
- The shifter itself is instantiated by the parent, not inside this block.

Test Plan:
1. req0 SHR, data=0110, cnt=2, fill=1 → LOAD gives Q=0110, then 1011, then 1101; done=1, done_id=0, result=1101 exactly 4 cycles after accept.
2. req1 SHL, data=0110, cnt=1, fill=0 → result=1100, done_id=1, latency 3.
3. req0 SHR, cnt=0, data=1010 → no sh_sr pulse; result=1010 at latency 2.
4. req0 and req1 both valid with LOAD 0011 and 0101 → served in order req0 then req1; two done pulses with ids 0 then 1. With SHIFTER_CTRL_RR_EN, repeated contention alternates ids 0,1,0,1.
5. Drop clr mid-SHIFT (SHL, cnt=5, after 2 shifts) → all outputs 0 immediately and no done pulse. After clr releases, a READ returns the current sh_Q at latency 1.
6. READ with no prior load → sh_ld/sr/sl remain 0 throughout, result=sh_Q, busy high for exactly 1 cycle.
